// File: rtl/inv_sub_bytes_serial_if.sv
`default_nettype none
// ============================================================================
// Module   : inv_sub_bytes_serial_if
// Brief    : State-word in/out valid/ready handshakes for InvSubBytes stage.
// Revision : 1.0 - initial release
// ============================================================================
interface inv_sub_bytes_serial_if #(
  parameter int NBYTES = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [8*NBYTES-1:0]   in_state;
  logic                  out_valid;
  logic                  out_ready;
  logic [8*NBYTES-1:0]   out_state;

  // master: upstream producer plus downstream consumer; slave: the stage
  modport master (
    output in_valid, in_state, out_ready,
    input  in_ready, out_valid, out_state
  );

  modport slave (
    input  in_valid, in_state, out_ready,
    output in_ready, out_valid, out_state
  );
endinterface
`default_nettype wire

// File: rtl/inv_sub_bytes_serial.sv
`default_nettype none
// ============================================================================
// Module   : inv_sub_bytes_serial
// Brief    : Byte-serial InvSubBytes through an external registered inverse S-box ROM.
// Revision : 1.0 - initial release
// ============================================================================
module inv_sub_bytes_serial #(
  parameter int NBYTES = 16,
  parameter int CW     = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  inv_sub_bytes_serial_if.slave   bus,
  output logic [7:0]              sbox_din,
  input  logic [7:0]              sbox_dout
);

  localparam int            c_w    = 8 * NBYTES;
  localparam logic [CW-1:0] c_last = CW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [CW-1:0]   r_cnt;
  logic            r_rd_pending;
  logic [c_w-1:0]  r_in_sr;
  logic [c_w-1:0]  r_out_sr;
  logic            w_accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_accept      = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    sbox_din      = 8'h00;
    case (r_state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          w_accept     = 1'b1;
          w_next_state = ISSUE;
        end
      end
      ISSUE: begin
        sbox_din = r_in_sr[c_w-1 -: 8];
        if (r_cnt == c_last) begin
          w_next_state = DRAIN;
        end
      end
      DRAIN: begin
        w_next_state = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // ROM answers one cycle after the address, so capture trails issue by one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_rd_pending <= 1'b0;
      r_in_sr      <= '0;
      r_out_sr     <= '0;
    end else begin
      r_rd_pending <= (r_state == ISSUE);
      if (w_accept) begin
        r_in_sr <= bus.in_state;
        r_cnt   <= '0;
      end else if (r_state == ISSUE) begin
        r_in_sr <= {r_in_sr[c_w-9:0], 8'h00};
        r_cnt   <= r_cnt + CW'(1);
      end
      if (r_rd_pending) begin
        r_out_sr <= {r_out_sr[c_w-9:0], sbox_dout};
      end
    end
  end

  assign bus.out_state = r_out_sr;

endmodule
`default_nettype wire

// File: doc/inv_sub_bytes_serial.md
Name: inv_sub_bytes_serial

Overview:
Byte-serial InvSubBytes stage for the AES decryption datapath.
- Accepts a 128-bit state word over a valid/ready handshake.
- Streams its 16 bytes, one per cycle, into the team's registered inverse S-box ROM (1-cycle read latency).
- Reassembles the returned bytes into a 128-bit result and presents it over a second valid/ready handshake to the next decryption stage.
- The inverse S-box ROM is a separate instance, wired externally through the sbox_din/sbox_dout ports.

Parameters:
NBYTES, 16, number of bytes per state word; state width = 8*NBYTES. Only 16 is supported for AES; others are for test only.
CW, 5, width of the byte counter; must satisfy 2^CW > NBYTES.

Ports:
clk  input  1  system clock, rising edge; the only clock
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  upstream state word valid
in_ready  output  1  block can accept a state word
in_state  input  8*NBYTES  state word; byte 0 = bits [127:120], byte 15 = bits [7:0]
sbox_din  output  8  byte address to inverse S-box ROM
sbox_dout  input  8  ROM data; corresponds to sbox_din presented one cycle earlier
out_valid  output  1  result state word valid
out_ready  input  1  downstream accepts the result
out_state  output  8*NBYTES  InvSubBytes(in_state), same byte ordering

Behaviour:
- Interface fixed: one clock (clk); asynchronous, active-low reset (rst_n).
- Reset, asserted at any time including mid-operation:
  - state=IDLE, counter=0, rd_pending=0.
  - Input and output shift registers cleared to 0.
  - in_ready=1, out_valid=0, out_state=0, sbox_din=0.
  - Any block in flight is discarded.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge E: load in_sr<=in_state, cnt<=0, go to ISSUE.
- ISSUE:
  - sbox_din = in_sr[top byte]; byte k is presented during cycle k after E.
  - Each edge: in_sr shifts left 8 (zero fill), cnt++, rd_pending<=1.
  - On the edge where cnt==NBYTES-1, go to DRAIN.
- Collection:
  - Whenever rd_pending=1 at an edge: out_sr<={out_sr[8*NBYTES-9:0], sbox_dout}.
  - rd_pending is a 1-cycle delayed copy of "in ISSUE".
  - Byte k is captured at edge E+k+2.
- DRAIN (one cycle): collects the final byte, then goes to DONE at edge E+NBYTES+1.
- DONE:
  - out_valid=1 and out_state=out_sr, held stable.
  - On out_valid&&out_ready: go to IDLE, out_valid drops the next cycle.
- Latency: accept edge E to out_valid high = NBYTES+1 = 17 cycles.
- Throughput: minimum period 19 cycles per block (IDLE 1, ISSUE 16, DRAIN 1, DONE 1 with out_ready=1).
- in_ready=0 in ISSUE, DRAIN and DONE; in_valid is ignored and in_state is not sampled there.
- sbox_din is 0 outside ISSUE, because in_sr is fully shifted out by the end of ISSUE.
- out_state holds its last value after leaving DONE until the next block's bytes shift in. Downstream must only use out_state qualified by out_valid.
- Backpressure: out_ready low in DONE holds the state indefinitely, with no change to out_state or sbox_din.
- in_valid and out_ready are simultaneous in DONE: out handshake completes; input is not accepted until IDLE.
- No combinational path from in_valid or out_ready to any output. All outputs derive from registers, except sbox_din (a mux of registered in_sr and the state).

Test Plan:
- Counting vector: in_state=128'h637c777bf26b6fc53001672bfed7ab76, out_ready=1 -> out_state=128'h000102030405060708090a0b0c0d0e0f; out_valid high exactly 17 cycles after the accept edge.
- All-zero input -> out_state=128'h525252...52 (16 bytes of 0x52). Input of all 0xff -> 16 bytes of 0x7d.
- Byte order and ROM timing: in_state=128'h01 followed by fifteen 0x00 bytes (byte 0 = 0x01) -> out_state=128'h09 followed by fifteen 0x52 bytes. sbox_din observed as 01,00,00,... in ISSUE cycles 0..15, then 0.
- Backpressure and busy: out_ready=0 for 5 cycles in DONE with in_valid=1 and a new in_state.
  - out_state and out_valid stay stable; in_ready=0.
  - After out_ready=1, one IDLE cycle, then the new block is accepted and its result is correct.
- Reset mid-operation: assert rst_n=0 at ISSUE cycle 8 -> immediately out_valid=0, out_state=0, in_ready=1, sbox_din=0. The next block after release produces the correct result with 17-cycle latency.
- Back-to-back: 4 random blocks with in_valid and out_ready held high -> results match a reference InvSubBytes model; accept edges spaced exactly 19 cycles apart.
